wb_pwm_ctrl: RTL and testbench

Wishbone B4 pipelined slave that generates CHANNELS independent PWM outputs from one shared period counter. It is the parametrised successor of the fixed wb_pwm block. It adds a programmable period (TOP), a clock prescaler, edge- or centre-aligned counting, per-channel output polarity, register readback, and double-buffered duty/period registers that take effect only on a period boundary. It sits on the SoC Wishbone bus and drives LEDs, motor or servo pins directly.

---
 rtl/wb_pwm_ctrl_pkg.sv | 13 +
 rtl/pwm_timebase.sv | 72 +++++++
 rtl/wb_pwm_ctrl.sv | 127 ++++++++++++
 tb/tb_wb_pwm_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pwm_ctrl_pkg.sv
// Register map and CTRL field positions shared by the PWM controller files.
package wb_pwm_ctrl_pkg;

  localparam logic [5:0] REG_CTRL     = 6'd0;
  localparam logic [5:0] REG_PERIOD   = 6'd1;
  localparam logic [5:0] REG_POLARITY = 6'd2;
  localparam logic [5:0] REG_DUTY0    = 6'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_CENTER    = 1;
  localparam int CTRL_PRESC_LSB = 8;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM time base: prescaler, up or up/down period counter and the
// period-boundary strobe that loads the double-buffered registers.
module pwm_timebase #(
  parameter int BITS       = 8,
  parameter int PRESC_BITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  center_i,
  input  logic [PRESC_BITS-1:0] presc_i,
  input  logic [BITS-1:0]       top_i,
  output logic [BITS-1:0]       cnt_o,
  output logic                  load_o
);

  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [BITS-1:0]       cnt_q, cnt_d;
  logic                  down_q, down_d;
  logic                  center_q;
  logic                  tick, restart, at_top, eff_down, boundary;

  assign tick     = en_i && (presc_q == presc_i);
  assign restart  = center_i != center_q;
  assign at_top   = cnt_q == top_i;
  // Reaching TOP while counting up is already the first downward step.
  assign eff_down = down_q || at_top;
  assign boundary = center_i ? (eff_down && (cnt_q == BITS'(1))) : at_top;
  assign load_o   = tick && boundary && !restart;
  assign cnt_o    = cnt_q;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    down_d  = down_q;
    if (!en_i || restart) begin
      presc_d = '0;
      cnt_d   = '0;
      down_d  = 1'b0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (!center_i) begin
          cnt_d = at_top ? '0 : cnt_q + 1'b1;
        end else if (top_i == '0) begin
          cnt_d  = '0;
          down_d = 1'b0;
        end else if (eff_down) begin
          cnt_d  = cnt_q - 1'b1;
          down_d = cnt_q != BITS'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      down_q   <= 1'b0;
      center_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      down_q   <= down_d;
      center_q <= center_i;
    end
  end

endmodule

// File: rtl/wb_pwm_ctrl.sv
// Wishbone pipelined slave with CHANNELS PWM outputs sharing one time base;
// PERIOD and DUTY are shadowed and move to the active copy on a period boundary.
module wb_pwm_ctrl
  import wb_pwm_ctrl_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int CHANNELS   = 3,
  parameter int PRESC_BITS = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_stall_o,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_o
);

  logic                  req;
  logic [5:0]            idx;
  logic                  unused_bits;

  logic                  en_q, center_q;
  logic [PRESC_BITS-1:0] presc_q;
  logic [CHANNELS-1:0]   pol_q;
  logic [BITS-1:0]       top_sh_q, top_act_q;
  logic [BITS-1:0]       duty_sh_q  [CHANNELS];
  logic [BITS-1:0]       duty_act_q [CHANNELS];

  logic                  ack_q, period_q;
  logic [31:0]           dat_q, rdata_d;
  logic [CHANNELS-1:0]   pwm_q;

  logic [BITS-1:0]       cnt;
  logic                  load;

  assign req         = wb_stb_i & wb_cyc_i;
  assign idx         = wb_adr_i[7:2];
  assign unused_bits = &{1'b0, wb_adr_i, wb_dat_i};

  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign pwm        = pwm_q;
  assign period_o   = period_q;

  always_comb begin
    rdata_d = '0;
    if (idx == REG_CTRL) begin
      rdata_d[CTRL_EN]                         = en_q;
      rdata_d[CTRL_CENTER]                     = center_q;
      rdata_d[CTRL_PRESC_LSB +: PRESC_BITS]    = presc_q;
    end
    if (idx == REG_PERIOD)   rdata_d[BITS-1:0]     = top_sh_q;
    if (idx == REG_POLARITY) rdata_d[CHANNELS-1:0] = pol_q;
    for (int n = 0; n < CHANNELS; n++) begin
      if (idx == REG_DUTY0 + 6'(n)) rdata_d[BITS-1:0] = duty_sh_q[n];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      center_q <= 1'b0;
      presc_q  <= '0;
      pol_q    <= '0;
      top_sh_q <= '0;
      for (int n = 0; n < CHANNELS; n++) duty_sh_q[n] <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb_we_i) ? rdata_d : '0;
      if (req && wb_we_i) begin
        if (idx == REG_CTRL) begin
          en_q     <= wb_dat_i[CTRL_EN];
          center_q <= wb_dat_i[CTRL_CENTER];
          presc_q  <= wb_dat_i[CTRL_PRESC_LSB +: PRESC_BITS];
        end
        if (idx == REG_PERIOD)   top_sh_q <= wb_dat_i[BITS-1:0];
        if (idx == REG_POLARITY) pol_q    <= wb_dat_i[CHANNELS-1:0];
        for (int n = 0; n < CHANNELS; n++) begin
          if (idx == REG_DUTY0 + 6'(n)) duty_sh_q[n] <= wb_dat_i[BITS-1:0];
        end
      end
    end
  end

  // While disabled the active set tracks the shadows so writes apply at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      top_act_q <= '0;
      for (int n = 0; n < CHANNELS; n++) duty_act_q[n] <= '0;
      period_q  <= 1'b0;
      pwm_q     <= '0;
    end else begin
      if (!en_q || load) begin
        top_act_q <= top_sh_q;
        for (int n = 0; n < CHANNELS; n++) duty_act_q[n] <= duty_sh_q[n];
      end
      period_q <= load;
      for (int n = 0; n < CHANNELS; n++) begin
        pwm_q[n] <= en_q ? ((cnt < duty_act_q[n]) ^ pol_q[n]) : pol_q[n];
      end
    end
  end

  pwm_timebase #(
    .BITS       (BITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_timebase (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .en_i     (en_q),
    .center_i (center_q),
    .presc_i  (presc_q),
    .top_i    (top_act_q),
    .cnt_o    (cnt),
    .load_o   (load)
  );

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// Self-checking bench for wb_pwm_ctrl: bus register model plus a waveform
// model that derives period length and high time from the counting rules.
module tb_wb_pwm_ctrl;

  localparam int BITS = 8;
  localparam int CH   = 3;
  localparam int PB   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb, cyc, we;
  logic [31:0]   adr, dat_w, dat_r;
  logic          stall, ack;
  logic [CH-1:0] pwm;
  logic          period;

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [31:0]   exp_reg [16];
  int            meas_per;
  int            meas_hi [CH];

  always #5 clk = ~clk;

  wb_pwm_ctrl #(.BITS(BITS), .CHANNELS(CH), .PRESC_BITS(PB)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb_stb_i   (stb),
    .wb_cyc_i   (cyc),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_dat_o   (dat_r),
    .wb_stall_o (stall),
    .wb_ack_o   (ack),
    .pwm        (pwm),
    .period_o   (period)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mask_of(input int idx);
    case (idx)
      0:       return 32'h0000_FF03;
      1:       return 32'h0000_00FF;
      2:       return 32'h0000_0007;
      3, 4, 5: return 32'h0000_00FF;
      default: return 32'h0;
    endcase
  endfunction

  // Counter values visited in one period, straight from the counting rules.
  function automatic int seq_len(input bit center, input int top);
    return center ? 2 * top : top + 1;
  endfunction

  function automatic int seq_below(input bit center, input int top, input int duty);
    int s[$];
    int k = 0;
    for (int v = 0; v <= top; v++) s.push_back(v);
    if (center) for (int v = top - 1; v >= 1; v--) s.push_back(v);
    foreach (s[i]) if (s[i] < duty) k++;
    return k;
  endfunction

  task automatic wb_rw(input bit w, input int idx, input logic [31:0] d, output logic [31:0] r);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = 32'(idx) << 2; dat_w = d;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("ack", {31'b0, ack}, 32'd1);
    r = dat_r;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] r;
    wb_rw(1'b1, idx, d, r);
    exp_reg[idx] = d & mask_of(idx);
  endtask

  task automatic rd_chk(input string tag, input int idx);
    logic [31:0] r;
    wb_rw(1'b0, idx, 32'h0, r);
    chk(tag, r, exp_reg[idx]);
  endtask

  // Window = cycles after one period_o pulse up to and including the next.
  task automatic measure();
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = period;
    end
    chk("period_start", {31'b0, seen}, 32'd1);
    meas_per = 0;
    for (int c = 0; c < CH; c++) meas_hi[c] = 0;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      meas_per++;
      for (int c = 0; c < CH; c++) meas_hi[c] += int'(pwm[c]);
      seen = period;
    end
    chk("period_end", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int acks;
    int duty [CH];
    bit c_mode;
    int presc, top, pol, per_e, hi_e;

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    for (int i = 0; i < 16; i++) exp_reg[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_pwm",    32'(pwm),             32'h0);
    chk("rst_ack",    {31'b0, ack},         32'h0);
    chk("rst_dat",    dat_r,                32'h0);
    chk("rst_period", {31'b0, period},      32'h0);
    chk("rst_stall",  {31'b0, stall},       32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rd_chk("rst_read", i);

    // Edge mode, TOP=9, DUTY0=3
    wr(1, 9); wr(3, 3); wr(0, 32'h1);
    measure(); measure();
    chk("edge_per", 32'(meas_per), 32'd10);
    chk("edge_hi0", 32'(meas_hi[0]), 32'd3);

    wr(0, 32'h101);
    measure(); measure();
    chk("presc_per", 32'(meas_per), 32'd20);
    chk("presc_hi0", 32'(meas_hi[0]), 32'd6);

    // Shadowed DUTY write mid-period: readback immediate, waveform next period
    wr(0, 32'h1);
    measure();
    repeat (4) @(negedge clk);
    wr(3, 7);
    rd_chk("duty_readback", 3);
    measure();
    chk("duty_new_hi0", 32'(meas_hi[0]), 32'd7);

    // Centre mode, TOP=8, DUTY1=2
    wr(1, 8); wr(4, 2); wr(2, 0); wr(0, 32'h3);
    measure(); measure();
    chk("ctr_per", 32'(meas_per), 32'(seq_len(1'b1, 8)));
    chk("ctr_hi1", 32'(meas_hi[1]), 32'(seq_below(1'b1, 8, 2)));
    wr(2, 32'h2);
    measure(); measure();
    chk("ctr_inv_hi1", 32'(meas_hi[1]), 32'(seq_len(1'b1, 8) - seq_below(1'b1, 8, 2)));
    wr(0, 32'h2);
    repeat (3) @(negedge clk);
    chk("dis_pwm", 32'(pwm), 32'h2);
    chk("dis_period", {31'b0, period}, 32'h0);

    // Duty extremes at TOP=9
    wr(2, 0); wr(1, 9); wr(5, 0); wr(0, 32'h1);
    measure(); measure();
    chk("duty0_low", 32'(meas_hi[2]), 32'd0);
    wr(5, 10);
    measure(); measure();
    chk("duty_over_top", 32'(meas_hi[2]), 32'd10);

    // Back-to-back writes with stb held
    acks = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1; cyc = 1'b1; we = 1'b1;
      adr = 32'(i + 1) << 2;
      dat_w = 32'hA0 + 32'(i);
      exp_reg[i + 1] = dat_w & mask_of(i + 1);
      @(posedge clk); #1;
      acks += int'(ack);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("b2b_acks", 32'(acks), 32'd4);
    chk("b2b_ack_idle", {31'b0, ack}, 32'd0);
    for (int i = 1; i < 5; i++) rd_chk("b2b_read", i);

    // Random register traffic including unmapped words
    for (int i = 0; i < 30; i++) begin
      int a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) wr(a, $urandom);
      else rd_chk("rand_read", a);
    end
    for (int i = 0; i < 16; i++) rd_chk("rand_final", i);

    // Random waveform configurations against the counting model
    for (int t = 0; t < 8; t++) begin
      c_mode = 1'($urandom_range(0, 1));
      presc  = $urandom_range(0, 3);
      top    = $urandom_range(1, 20);
      pol    = $urandom_range(0, 7);
      wr(1, 32'(top));
      wr(2, 32'(pol));
      for (int c = 0; c < CH; c++) begin
        duty[c] = $urandom_range(0, top + 2);
        wr(3 + c, 32'(duty[c]));
      end
      wr(0, 32'h1 | (32'(c_mode) << 1) | (32'(presc) << 8));
      measure(); measure();
      per_e = seq_len(c_mode, top) * (presc + 1);
      chk("rnd_per", 32'(meas_per), 32'(per_e));
      for (int c = 0; c < CH; c++) begin
        hi_e = seq_below(c_mode, top, duty[c]) * (presc + 1);
        if (pol[c]) hi_e = per_e - hi_e;
        chk("rnd_hi", 32'(meas_hi[c]), 32'(hi_e));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
